// File: rtl/note_recorder.sv
// Live key-press recorder: encodes held keys into {note, band, time_len} song words
// and streams them to song RAM, closing each recording with a zero-length terminator.
module note_recorder #(
  parameter int          CLK_HZ   = 50000000,
  parameter int          TICK_DIV = CLK_HZ / 8,
  parameter logic [15:0] END_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] key,
  input  logic [2:0]  band,
  input  logic [15:0] base_addr,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] last_addr
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_TERM    = 2'd3;

  logic [1:0]    state;
  logic [15:0]   ptr;
  logic [TW-1:0] tick;
  logic [4:0]    units;
  logic [3:0]    cur_idx;
  logic [2:0]    cur_band;
  logic [11:0]   word;
  logic          stop_hit;

  logic [3:0] idx;
  logic       key_chg;
  logic       sat;

  // Highest pressed key wins; bit 0 never selects a note.
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (key[i] && i != 0) idx = 4'(i);
  end

  assign key_chg = (idx != cur_idx);
  assign sat     = (units == 5'd31);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      tick      <= '0;
      units     <= '0;
      cur_idx   <= '0;
      cur_band  <= '0;
      word      <= '0;
      stop_hit  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      last_addr <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= start;
          if (start) begin
            ptr      <= base_addr;
            overflow <= 1'b0;
            cur_idx  <= idx;
            cur_band <= band;
            tick     <= '0;
            units    <= '0;
            state    <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (key_chg || sat || stop) begin
            // Word is frozen now so the emitted length reflects this edge's count.
            word     <= {cur_idx, cur_band, (units == 5'd0) ? 5'd1 : units};
            stop_hit <= stop;
            if (key_chg && !stop) begin
              cur_idx  <= idx;
              cur_band <= band;
            end
            state <= S_EMIT;
          end else if (tick == TICK_LAST) begin
            tick  <= '0;
            units <= units + 5'd1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_EMIT: begin
          wr_en   <= 1'b1;
          wr_addr <= ptr;
          wr_data <= word;
          ptr     <= ptr + 16'd1;
          tick    <= '0;
          units   <= '0;
          if (stop_hit) begin
            state <= S_TERM;
          end else if (ptr + 16'd1 == END_ADDR) begin
            overflow <= 1'b1;
            state    <= S_TERM;
          end else begin
            state <= S_MEASURE;
          end
        end
        S_TERM: begin
          wr_en     <= 1'b1;
          wr_addr   <= ptr;
          wr_data   <= 12'h000;
          last_addr <= ptr;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed scenarios plus random recordings, checked every
// cycle against an event-level reference model that measures durations by division.
module tb_note_recorder;

  localparam int          TD  = 4;
  localparam logic [15:0] END = 16'h0202;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [15:0] key, base_addr;
  logic [2:0]  band;
  logic        wr_en, busy, overflow;
  logic [15:0] wr_addr, last_addr;
  logic [11:0] wr_data;

  note_recorder #(.CLK_HZ(32), .TICK_DIV(TD), .END_ADDR(END)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .key(key), .band(band),
    .base_addr(base_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .overflow(overflow), .last_addr(last_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_active;
  int          m_gap;      // 0 measuring, 1 word pending, 2 terminator pending
  int          m_elapsed;  // counted cycles of the open event
  int          m_idx, m_band;
  bit          m_stop;
  logic [15:0] m_ptr;
  logic [11:0] m_word;
  logic        e_wr, e_busy, e_ovf;
  logic [15:0] e_addr, e_last;
  logic [11:0] e_data;

  logic [11:0] log_d[$];
  logic [15:0] log_a[$];

  function automatic int f_idx(input logic [15:0] k);
    for (int i = 15; i >= 1; i--) if (k[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic m_step();
    int u, ni;
    if (rst) begin
      m_active = 0; m_gap = 0; m_elapsed = 0; m_ptr = '0;
      e_wr = 0; e_addr = '0; e_data = '0; e_busy = 0; e_ovf = 0; e_last = '0;
      return;
    end
    e_wr = 0;
    if (!m_active) begin
      e_busy = start;
      if (start) begin
        m_active = 1; m_gap = 0; m_elapsed = 0; m_ptr = base_addr; e_ovf = 0;
        m_idx = f_idx(key); m_band = int'(band);
      end
    end else if (m_gap == 1) begin
      e_wr = 1; e_addr = m_ptr; e_data = m_word;
      m_ptr = m_ptr + 16'd1; m_elapsed = 0;
      if (m_stop) m_gap = 2;
      else if (m_ptr == END) begin e_ovf = 1; m_gap = 2; end
      else m_gap = 0;
    end else if (m_gap == 2) begin
      e_wr = 1; e_addr = m_ptr; e_data = 12'h000; e_last = m_ptr;
      m_active = 0; m_gap = 0;
    end else begin
      u  = (m_elapsed / TD > 31) ? 31 : m_elapsed / TD;
      ni = f_idx(key);
      if (ni != m_idx || u == 31 || stop) begin
        m_word = {4'(m_idx), 3'(m_band), 5'((u == 0) ? 1 : u)};
        m_stop = stop;
        if (ni != m_idx && !stop) begin m_idx = ni; m_band = int'(band); end
        m_gap = 1;
      end else begin
        m_elapsed++;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then check all outputs.
  task automatic cyc(input logic [15:0] k, input logic [2:0] b, input logic s, input logic p);
    key = k; band = b; start = s; stop = p;
    @(posedge clk);
    m_step();
    #1;
    chk("wr_en", 16'(wr_en), 16'(e_wr));
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", 16'(wr_data), 16'(e_data));
    chk("busy", 16'(busy), 16'(e_busy));
    chk("overflow", 16'(overflow), 16'(e_ovf));
    chk("last_addr", last_addr, e_last);
    if (wr_en === 1'b1) begin log_d.push_back(wr_data); log_a.push_back(wr_addr); end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(16'h0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; base_addr = 16'h0100;
    cyc(16'h0, 3'd0, 1'b0, 1'b0);
    cyc(16'h0, 3'd0, 1'b0, 1'b0);
    chk("reset_wr_en", 16'(wr_en), 16'h0);
    chk("reset_busy", 16'(busy), 16'h0);
    rst = 1'b0;
    idle(2);
    chk("idle_no_write", 16'(log_d.size()), 16'h0);

    // Basic note + rest + terminator
    log_d.delete(); log_a.delete();
    cyc(16'h0020, 3'd3, 1'b1, 1'b0);
    repeat (10) cyc(16'h0020, 3'd3, 1'b0, 1'b0);
    repeat (10) cyc(16'h0000, 3'd3, 1'b0, 1'b0);
    cyc(16'h0000, 3'd3, 1'b0, 1'b1);
    repeat (2) cyc(16'h0000, 3'd3, 1'b0, 1'b0);
    chk("t1_count", 16'(log_d.size()), 16'd3);
    if (log_d.size() == 3) begin
      chk("t1_w0", 16'(log_d[0]), 16'h0562);
      chk("t1_w1", 16'(log_d[1]), 16'h0062);
      chk("t1_w2", 16'(log_d[2]), 16'h0000);
      chk("t1_a2", log_a[2], 16'h0102);
    end
    chk("t1_last", last_addr, 16'h0102);
    chk("t1_busy_hi", 16'(busy), 16'h1);
    cyc(16'h0, 3'd0, 1'b0, 1'b0);
    chk("t1_busy_lo", 16'(busy), 16'h0);

    // Short press clamps to len 1
    log_d.delete(); log_a.delete();
    cyc(16'h0, 3'd0, 1'b1, 1'b0);
    idle(5);
    repeat (2) cyc(16'h8000, 3'd0, 1'b0, 1'b0);
    idle(5);
    cyc(16'h0, 3'd0, 1'b0, 1'b1);
    idle(3);
    chk("t2_count", 16'(log_d.size()), 16'd4);
    if (log_d.size() == 4) chk("t2_short", 16'(log_d[1]), 16'h0F01);

    // Long hold splits at 31 units
    log_d.delete(); log_a.delete();
    cyc(16'h0002, 3'd7, 1'b1, 1'b0);
    repeat (140) cyc(16'h0002, 3'd7, 1'b0, 1'b0);
    cyc(16'h0002, 3'd7, 1'b0, 1'b1);
    idle(3);
    chk("t3_count", 16'(log_d.size()), 16'd3);
    if (log_d.size() == 3) begin
      chk("t3_sat", 16'(log_d[0]), 16'h01FF);
      chk("t3_rem_hi", 16'(log_d[1][11:5]), 16'h000F);
      chk("t3_term", 16'(log_d[2]), 16'h0000);
    end

    // Stop coincident with key change: one word then terminator
    log_d.delete(); log_a.delete();
    cyc(16'h0024, 3'd2, 1'b1, 1'b0);
    repeat (6) cyc(16'h0024, 3'd2, 1'b0, 1'b0);
    cyc(16'h0100, 3'd2, 1'b0, 1'b1);
    repeat (3) cyc(16'h0100, 3'd2, 1'b0, 1'b0);
    chk("t4_count", 16'(log_d.size()), 16'd2);
    if (log_d.size() == 2) begin
      chk("t4_w0", 16'(log_d[0]), 16'h0541);
      chk("t4_w1", 16'(log_d[1]), 16'h0000);
    end

    // Overflow at END_ADDR
    log_d.delete(); log_a.delete();
    base_addr = 16'h0200;
    cyc(16'h0002, 3'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 6; i++) repeat (3) cyc(16'(1 << i), 3'd1, 1'b0, 1'b0);
    idle(3);
    chk("t5_count", 16'(log_d.size()), 16'd3);
    if (log_d.size() == 3) begin
      chk("t5_a0", log_a[0], 16'h0200);
      chk("t5_a1", log_a[1], 16'h0201);
      chk("t5_term", 16'(log_d[2]), 16'h0000);
    end
    chk("t5_ovf", 16'(overflow), 16'h1);
    chk("t5_last", last_addr, 16'h0202);
    base_addr = 16'h0100;
    cyc(16'h0, 3'd0, 1'b1, 1'b0);
    chk("t5_ovf_clr", 16'(overflow), 16'h0);

    // Reset mid-measure aborts, then start+stop together starts recording
    repeat (5) cyc(16'h0010, 3'd4, 1'b0, 1'b0);
    log_d.delete(); log_a.delete();
    rst = 1'b1; cyc(16'h0010, 3'd4, 1'b0, 1'b0); rst = 1'b0;
    repeat (6) cyc(16'h0020, 3'd4, 1'b0, 1'b0);
    chk("t6_no_write", 16'(log_d.size()), 16'h0);
    chk("t6_busy", 16'(busy), 16'h0);
    chk("t6_last", last_addr, 16'h0);
    cyc(16'h0008, 3'd5, 1'b1, 1'b1);
    chk("t6_start_stop", 16'(busy), 16'h1);
    repeat (5) cyc(16'h0008, 3'd5, 1'b0, 1'b0);
    cyc(16'h0008, 3'd5, 1'b0, 1'b1);
    idle(3);

    // Random recordings
    for (int r = 0; r < 24; r++) begin
      logic [15:0] k;
      logic [2:0]  b;
      int          nseg, hold;
      base_addr = (r % 4 == 3) ? 16'($urandom_range(16'h01F8, 16'h0201))
                               : 16'($urandom_range(16'h0100, 16'h01F0));
      k = 16'($urandom); b = 3'($urandom);
      cyc(k, b, 1'b1, 1'b0);
      nseg = $urandom_range(1, 8);
      for (int s = 0; s < nseg; s++) begin
        hold = ($urandom % 6 == 0) ? $urandom_range(120, 140) : $urandom_range(2, 15);
        for (int h = 0; h < hold; h++)
          cyc(k, (h == 0) ? b : 3'($urandom), ($urandom % 8) == 0, ($urandom % 40) == 0);
        k = ($urandom % 3 == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 15));
        b = 3'($urandom);
      end
      cyc(k, b, 1'b0, 1'b1);
      idle(4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
